latex_stream_checker: RTL and testbench

Receive-side counterpart of the transform character generator: accepts a streamed ASCII LaTeX string over a valid/ready handshake and checks it byte-by-byte against the string stored in `memory_chars` for a given line and side (function or Laplace transform). It shares the `line_mapper` and `memory_chars` lookup path and reports pass/fail plus the byte index of the first discrepancy. It serves as the on-chip self-check and loopback verifier for the character outputs.

---
 rtl/latex_stream_checker_if.sv | 22 ++
 rtl/latex_stream_checker.sv | 193 +++++++++++++++++++
 tb/tb_latex_stream_checker.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/latex_stream_checker_if.sv
// Byte stream handshake into latex_stream_checker.
// Master drives data/valid/last, slave returns ready.
interface latex_stream_checker_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/latex_stream_checker.sv
// Checks a streamed LaTeX string against memory_chars for one line/side.
// Optional CHECKER_DRAIN_EN: after a fail, swallow bytes until in_last.
module latex_stream_checker #(
    parameter int MAX_BYTES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [5:0]                   line,
    input  logic                         sel,
    latex_stream_checker_if.slave        stream,
    output logic [7:0]                   line_out,
    input  logic [15:0]                  pointer_addr,
    output logic [7:0]                   mem_addr,
    input  logic [15:0]                  mem_dout,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [7:0]                   err_idx
);

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        FETCH,
        WAIT,
        CMP_HI,
        CMP_LO,
        CHK_END,
`ifdef CHECKER_DRAIN_EN
        DRAIN,
`endif
        DONE
    } state_t;

`ifdef CHECKER_DRAIN_EN
    localparam state_t OPEN_FAIL = DRAIN;
`else
    localparam state_t OPEN_FAIL = DONE;
`endif

    localparam logic [7:0] MAX_IDX = 8'(MAX_BYTES);

    state_t      state, state_n;
    logic [5:0]  line_q;
    logic        sel_q;
    logic [7:0]  wptr, wptr_n;
    logic [15:0] word;
    logic [7:0]  idx, idx_n;
    logic        half, half_n;
    logic        tail_pend, tail_n;
    logic        res_pass, res_pass_n;
    logic [7:0]  res_idx, res_idx_n;
    logic [7:0]  exp_b;
    logic        stop;
    logic        rdy;
    logic        hs;
    logic        fail;
    logic        fail_open;

    // CHK_END looks at the low byte only when the last match was a high byte
    always_comb begin
        unique case (state)
            CMP_LO:  exp_b = word[7:0];
            CHK_END: exp_b = half ? word[7:0] : word[15:8];
            default: exp_b = word[15:8];
        endcase
    end

    assign stop = (exp_b == 8'h00) || (idx == MAX_IDX);

    always_comb begin
        rdy = (state == CMP_HI || state == CMP_LO) && !stop;
`ifdef CHECKER_DRAIN_EN
        if (state == DRAIN) rdy = 1'b1;
`endif
    end

    assign hs              = stream.in_valid && rdy;
    assign stream.in_ready = rdy;
    assign line_out        = {2'b00, line_q};
    assign mem_addr        = wptr;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

    always_comb begin
        state_n    = state;
        wptr_n     = wptr;
        idx_n      = idx;
        half_n     = half;
        tail_n     = tail_pend;
        res_pass_n = res_pass;
        res_idx_n  = res_idx;
        fail       = 1'b0;
        fail_open  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = LOOKUP;
                    idx_n      = 8'd0;
                    half_n     = 1'b0;
                    tail_n     = 1'b0;
                    res_pass_n = 1'b0;
                    res_idx_n  = 8'd0;
                end
            end
            LOOKUP: begin
                wptr_n  = sel_q ? pointer_addr[15:8]
                                : pointer_addr[7:0];
                state_n = FETCH;
            end
            FETCH: state_n = WAIT;
            WAIT:  state_n = tail_pend ? CHK_END : CMP_HI;
            CMP_HI, CMP_LO: begin
                if (stop) begin
                    fail      = 1'b1;
                    fail_open = 1'b1;
                end else if (hs) begin
                    if (stream.in_data != exp_b) begin
                        fail      = 1'b1;
                        fail_open = !stream.in_last;
                    end else begin
                        idx_n = idx + 8'd1;
                        if (state == CMP_HI) begin
                            half_n  = stream.in_last;
                            state_n = stream.in_last ? CHK_END : CMP_LO;
                        end else begin
                            half_n  = 1'b0;
                            tail_n  = stream.in_last;
                            wptr_n  = wptr + 8'd1;
                            state_n = FETCH;
                        end
                    end
                end
            end
            CHK_END: begin
                res_pass_n = (exp_b == 8'h00);
                res_idx_n  = idx;
                state_n    = DONE;
            end
`ifdef CHECKER_DRAIN_EN
            DRAIN: begin
                if (stream.in_valid && stream.in_last) state_n = DONE;
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (fail) begin
            res_pass_n = 1'b0;
            res_idx_n  = idx;
            state_n    = fail_open ? OPEN_FAIL : DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            line_q    <= 6'd0;
            sel_q     <= 1'b0;
            wptr      <= 8'd0;
            word      <= 16'd0;
            idx       <= 8'd0;
            half      <= 1'b0;
            tail_pend <= 1'b0;
            res_pass  <= 1'b0;
            res_idx   <= 8'd0;
            pass      <= 1'b0;
            err_idx   <= 8'd0;
        end else begin
            state     <= state_n;
            wptr      <= wptr_n;
            idx       <= idx_n;
            half      <= half_n;
            tail_pend <= tail_n;
            res_pass  <= res_pass_n;
            res_idx   <= res_idx_n;
            if (state == IDLE && start) begin
                line_q  <= line;
                sel_q   <= sel;
                pass    <= 1'b0;
                err_idx <= 8'd0;
            end
            if (state == WAIT) word <= mem_dout;
            // results become visible together with done
            if (state_n == DONE && state != DONE) begin
                pass    <= res_pass_n;
                err_idx <= res_idx_n;
            end
        end
    end

endmodule

// File: tb/tb_latex_stream_checker.sv
// Randomized and directed bench for latex_stream_checker.
// Expected results come from a string-level model of the check.
`timescale 1ns/1ps
module tb_latex_stream_checker;

    localparam int MAX = 64;
`ifdef CHECKER_DRAIN_EN
    localparam bit DRAIN_ON = 1'b1;
`else
    localparam bit DRAIN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  line;
    logic        sel;
    logic [7:0]  line_out;
    logic [15:0] pointer_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_idx;

    latex_stream_checker_if sif ();

    latex_stream_checker #(.MAX_BYTES(MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .line         (line),
        .sel          (sel),
        .stream       (sif),
        .line_out     (line_out),
        .pointer_addr (pointer_addr),
        .mem_addr     (mem_addr),
        .mem_dout     (mem_dout),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_idx      (err_idx)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [15:0] map [64];

    always @(posedge clk) mem_dout <= mem[mem_addr];
    assign pointer_addr = map[line_out[5:0]];

    byte unsigned exp_q[$];
    byte unsigned stim[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic set_str(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic set_stim(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // place exp_q (NUL terminated, word packed) at ptr for line/side
    task automatic load(input logic [5:0] ln, input bit s, input logic [7:0] ptr);
        int len;
        logic [15:0] m;
        logic [7:0] hi, lo, a;
        len = exp_q.size();
        m = map[ln];
        if (s) m[15:8] = ptr;
        else   m[7:0]  = ptr;
        map[ln] = m;
        for (int i = 0; i <= len; i += 2) begin
            hi = (i < len)     ? exp_q[i]     : 8'h00;
            lo = (i + 1 < len) ? exp_q[i + 1] : 8'h00;
            a  = ptr + 8'(i / 2);
            mem[a] = {hi, lo};
        end
    endtask

    // string-level view: walk the received bytes against the stored text
    function automatic void model(input bit has_last, output bit p,
                                  output int idx, output int cons);
        int L;
        int n;
        bit open;
        byte unsigned e, nx;
        L = exp_q.size();
        n = stim.size();
        open = 1'b0;
        p = 1'b0;
        idx = 0;
        cons = 0;
        for (int i = 0; i < n; i++) begin
            e = (i < L) ? exp_q[i] : 8'h00;
            if (e == 8'h00 || i == MAX) begin
                idx = i; cons = i; open = 1'b1;
                break;
            end
            if (stim[i] != e) begin
                idx = i; cons = i + 1;
                open = !(has_last && i == n - 1);
                break;
            end
            if (has_last && i == n - 1) begin
                nx = (i + 1 < L) ? exp_q[i + 1] : 8'h00;
                p = (nx == 8'h00);
                idx = i + 1; cons = i + 1;
                break;
            end
        end
        if (open && DRAIN_ON && has_last) cons = n;
    endfunction

    task automatic run(input logic [5:0] ln, input bit s, input bit has_last,
                       input bit gaps, input int poke,
                       output bit got_pass, output logic [7:0] got_idx,
                       output int cons, output int rdy_c, output int done_c,
                       output bit busy_ok, output bit tail_ok,
                       output logic [7:0] lo_done);
        int pos;
        int n;
        n = stim.size();
        pos = 0;
        rdy_c = -1;
        done_c = -1;
        got_pass = 1'b0;
        got_idx = 8'd0;
        busy_ok = 1'b0;
        tail_ok = 1'b0;
        lo_done = 8'd0;
        @(negedge clk);
        start = 1'b1; line = ln; sel = s;
        sif.in_valid = 1'b0;
        for (int c = 1; c <= 1500; c++) begin
            @(negedge clk);
            start = (c == poke);
            line  = (c == poke) ? 6'd7 : 6'($urandom);
            sel   = 1'($urandom);
            if (sif.in_ready && rdy_c < 0) rdy_c = c;
            if (done) begin
                done_c = c;
                got_pass = pass;
                got_idx = err_idx;
                busy_ok = busy;
                lo_done = line_out;
                break;
            end
            if (pos < n) begin
                sif.in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
                sif.in_data  = stim[pos];
                sif.in_last  = has_last && (pos == n - 1);
            end else begin
                sif.in_valid = 1'b0;
            end
            if (sif.in_valid && sif.in_ready) pos++;
        end
        cons = pos;
        start = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_last = 1'b0;
        if (done_c < 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done, want done within 1500 cycles");
        end else begin
            @(negedge clk);
            tail_ok = !done && !busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; line = 6'd0; sel = 1'b0;
        sif.in_valid = 1'b0; sif.in_data = 8'h00; sif.in_last = 1'b0;
        repeat (2) @(negedge clk);
        n_vec += 7;
        if (sif.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", sif.in_ready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        if (pass !== 1'b0) begin n_err++; $display("FAIL rst_pass: got %b want 0", pass); end
        if (err_idx !== 8'd0) begin n_err++; $display("FAIL rst_err_idx: got %0d want 0", err_idx); end
        if (mem_addr !== 8'd0) begin n_err++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
        if (line_out !== 8'd0) begin n_err++; $display("FAIL rst_line_out: got %0d want 0", line_out); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        bit gp, bo, to;
        logic [7:0] gi, lo;
        int gc, rc, dc;
        set_str("t^2");
        load(6'd3, 1'b0, 8'h10);
        set_stim("t^2");
        run(6'd3, 1'b0, 1'b1, 1'b0, 0, gp, gi, gc, rc, dc, bo, to, lo);
        n_vec += 5;
        if (gp !== 1'b1) begin n_err++; $display("FAIL t2_pass: got %b want 1", gp); end
        if (gi !== 8'd3) begin n_err++; $display("FAIL t2_err_idx: got %0d want 3", gi); end
        if (rc != 4) begin n_err++; $display("FAIL t2_first_ready: got %0d want 4", rc); end
        if (dc != 10) begin n_err++; $display("FAIL t2_done_cycle: got %0d want 10", dc); end
        if (!(bo && to)) begin n_err++; $display("FAIL t2_busy_done: got %b%b want 11", bo, to); end

        set_stim("t^3");
        run(6'd3, 1'b0, 1'b1, 1'b0, 0, gp, gi, gc, rc, dc, bo, to, lo);
        n_vec += 2;
        if (gp !== 1'b0) begin n_err++; $display("FAIL t3_pass: got %b want 0", gp); end
        if (gi !== 8'd2) begin n_err++; $display("FAIL t3_err_idx: got %0d want 2", gi); end

        set_stim("t^");
        run(6'd3, 1'b0, 1'b1, 1'b0, 0, gp, gi, gc, rc, dc, bo, to, lo);
        n_vec += 2;
        if (gp !== 1'b0) begin n_err++; $display("FAIL short_pass: got %b want 0", gp); end
        if (gi !== 8'd2) begin n_err++; $display("FAIL short_err_idx: got %0d want 2", gi); end

`ifdef CHECKER_DRAIN_EN
        set_stim("t^2xy");
        run(6'd3, 1'b0, 1'b1, 1'b0, 0, gp, gi, gc, rc, dc, bo, to, lo);
        n_vec += 3;
        if (gc != 5) begin n_err++; $display("FAIL long_consumed: got %0d want 5", gc); end
`else
        set_stim("t^2x");
        run(6'd3, 1'b0, 1'b0, 1'b0, 0, gp, gi, gc, rc, dc, bo, to, lo);
        n_vec += 3;
        if (gc != 3) begin n_err++; $display("FAIL long_consumed: got %0d want 3", gc); end
`endif
        if (gp !== 1'b0) begin n_err++; $display("FAIL long_pass: got %b want 0", gp); end
        if (gi !== 8'd3) begin n_err++; $display("FAIL long_err_idx: got %0d want 3", gi); end
    endtask

    task automatic test_busy_start();
        bit gp, bo, to;
        logic [7:0] gi, lo;
        int gc, rc, dc;
        set_str("xyz");
        load(6'd7, 1'b0, 8'h40);
        set_str("t^2");
        load(6'd3, 1'b0, 8'h10);
        set_stim("t^2");
        run(6'd3, 1'b0, 1'b1, 1'b0, 5, gp, gi, gc, rc, dc, bo, to, lo);
        n_vec += 3;
        if (gp !== 1'b1) begin n_err++; $display("FAIL busy_start_pass: got %b want 1", gp); end
        if (gi !== 8'd3) begin n_err++; $display("FAIL busy_start_err_idx: got %0d want 3", gi); end
        if (lo !== 8'd3) begin n_err++; $display("FAIL busy_start_line: got %0d want 3", lo); end
    endtask

    task automatic test_reset_mid();
        bit gp, bo, to, saw_done;
        logic [7:0] gi, lo;
        int gc, rc, dc, pos;
        set_str("t^2");
        load(6'd3, 1'b0, 8'h10);
        set_stim("t^2");
        pos = 0;
        @(negedge clk);
        start = 1'b1; line = 6'd3; sel = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            sif.in_valid = 1'b1;
            sif.in_data = stim[pos];
            sif.in_last = 1'b0;
            if (sif.in_ready) pos++;
        end
        n_vec++;
        if (pos != 2) begin n_err++; $display("FAIL mid_bytes_before_rst: got %0d want 2", pos); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sif.in_valid = 1'b0;
        n_vec += 7;
        if (sif.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b want 0", sif.in_ready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", done); end
        if (pass !== 1'b0) begin n_err++; $display("FAIL mid_pass: got %b want 0", pass); end
        if (err_idx !== 8'd0) begin n_err++; $display("FAIL mid_err_idx: got %0d want 0", err_idx); end
        if (mem_addr !== 8'd0) begin n_err++; $display("FAIL mid_mem_addr: got %0d want 0", mem_addr); end
        if (line_out !== 8'd0) begin n_err++; $display("FAIL mid_line_out: got %0d want 0", line_out); end
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin n_err++; $display("FAIL mid_no_done: got done=1 want none"); end

        set_str("\\frac{2}{s^3}");
        load(6'd3, 1'b1, 8'h20);
        set_stim("\\frac{2}{s^3}");
        run(6'd3, 1'b1, 1'b1, 1'b0, 0, gp, gi, gc, rc, dc, bo, to, lo);
        n_vec += 2;
        if (gp !== 1'b1) begin n_err++; $display("FAIL rhs_pass: got %b want 1", gp); end
        if (gi !== 8'd13) begin n_err++; $display("FAIL rhs_err_idx: got %0d want 13", gi); end
    endtask

    task automatic test_random();
        bit gp, pm, bo, to;
        logic [7:0] gi, lo, ptr;
        logic [5:0] ln;
        bit s;
        int gc, rc, dc, im, cm, L, n, k, v;
        for (int t = 0; t < 50; t++) begin
            L = ($urandom_range(4) == 0) ? int'($urandom_range(80, 60))
                                         : int'($urandom_range(20, 0));
            exp_q.delete();
            for (int i = 0; i < L; i++)
                exp_q.push_back(8'($urandom_range(126, 32)));
            ln  = 6'($urandom_range(50));
            s   = 1'($urandom_range(1));
            ptr = 8'($urandom);
            load(ln, s, ptr);
            stim = exp_q;
            v = $urandom_range(3);
            if (v == 1 && L > 0) begin
                k = $urandom_range(L - 1);
                stim[k] = stim[k] ^ 8'h01;
            end else if (v == 2 && L > 1) begin
                n = $urandom_range(L - 1, 1);
                while (stim.size() > n) void'(stim.pop_back());
            end else if (v == 3) begin
                repeat ($urandom_range(5, 1))
                    stim.push_back(8'($urandom_range(126, 32)));
            end
            if (stim.size() == 0) stim.push_back(8'h41);
            model(1'b1, pm, im, cm);
            run(ln, s, 1'b1, 1'($urandom_range(1)), 0,
                gp, gi, gc, rc, dc, bo, to, lo);
            n_vec += 5;
            if (gp !== pm) begin n_err++; $display("FAIL rnd%0d_pass: got %b want %b", t, gp, pm); end
            if (gi !== 8'(im)) begin n_err++; $display("FAIL rnd%0d_err_idx: got %0d want %0d", t, gi, im); end
            if (gc != cm) begin n_err++; $display("FAIL rnd%0d_consumed: got %0d want %0d", t, gc, cm); end
            if (!bo) begin n_err++; $display("FAIL rnd%0d_busy_at_done: got 0 want 1", t); end
            if (!to) begin n_err++; $display("FAIL rnd%0d_done_pulse: got done/busy high want low", t); end
            if (L > 0) begin
                n_vec++;
                if (rc != 4) begin n_err++; $display("FAIL rnd%0d_first_ready: got %0d want 4", t, rc); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {8'($urandom_range(126, 32)), 8'($urandom_range(126, 32))};
        for (int i = 0; i < 64; i++)
            map[i] = 16'($urandom);
        test_reset();
        test_directed();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
